// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared constants and types for the VGA framebuffer arbiter.
//                Display geometry, framebuffer depth, data/address widths,
//                blanking colour and the RAM port-owner encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_pkg;

   localparam int H_RES    = 640;            // active pixels per line
   localparam int V_RES    = 480;            // active lines
   localparam int FB_DEPTH = H_RES * V_RES;  // framebuffer words
   localparam int ADDR_W   = 19;             // ceil(log2(FB_DEPTH))
   localparam int PIXEL_W  = 8;              // RGB 3-3-2
   localparam int COORD_W  = 10;             // X/Y coordinate width
   localparam int STALL_W  = 16;             // write-stall counter width

   localparam logic [PIXEL_W-1:0] BLANK_COLOR = 8'h05;

   // Who owns the single RAM port in a given cycle.
   typedef enum logic [1:0] {
      OWN_IDLE = 2'd0,
      OWN_RD   = 2'd1,
      OWN_WR   = 2'd2
   } owner_e;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/fb_addr_calc.sv
`default_nettype none
// ============================================================================
//  Module      : fb_addr_calc
//  Description : Combinational framebuffer address generator. Forms
//                Y*H_RES + X at full ADDR_W width and flags whether the
//                coordinate lies inside the visible window.
//  Ports       : active_i  - timing generator says pixel is in the window
//                x_i, y_i  - visible-area column / row
//                addr_o    - linear framebuffer address
//                visible_o - request must be fetched from RAM
//  Revision    : 1.0  initial release
// ============================================================================
module fb_addr_calc
   import vga_pkg::*;
(
   input  logic               active_i,
   input  logic [COORD_W-1:0] x_i,
   input  logic [COORD_W-1:0] y_i,
   output logic [ADDR_W-1:0]  addr_o,
   output logic               visible_o
);

   localparam logic [COORD_W-1:0] H_LIM = COORD_W'(H_RES);
   localparam logic [COORD_W-1:0] V_LIM = COORD_W'(V_RES);

   logic [ADDR_W-1:0] w_x_ext;
   logic [ADDR_W-1:0] w_y_ext;
   logic [ADDR_W-1:0] w_row_base;

   // Zero-extend before any arithmetic so nothing is lost above bit 9.
   assign w_x_ext = {{(ADDR_W-COORD_W){1'b0}}, x_i};
   assign w_y_ext = {{(ADDR_W-COORD_W){1'b0}}, y_i};

   generate
      if (H_RES == 640) begin : g_shift_add
         // 640 = 512 + 128
         assign w_row_base = (w_y_ext << 9) + (w_y_ext << 7);
      end else begin : g_mult
         assign w_row_base = w_y_ext * ADDR_W'(H_RES);
      end
   endgenerate

   assign addr_o    = w_row_base + w_x_ext;
   assign visible_o = active_i && (x_i < H_LIM) && (y_i < V_LIM);

endmodule : fb_addr_calc
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_fb_arbiter
//  Description : Shares one single-port framebuffer RAM between VGA scanout
//                reads (absolute priority, fixed 3-cycle latency) and host
//                writes over a valid/ready handshake using the free slots.
//  Ports       : CLK_IN, RST (async, active-high)
//                PXL_EN, DISP_ACTIVE, X_COORD, Y_COORD - scanout request
//                RGB_OUT                               - registered colour
//                WR_VALID/WR_READY/WR_ADDR/WR_DATA     - host write port
//                WR_ERR    - sticky out-of-range write flag
//                STALL_CNT - saturating count of denied write cycles
//                MEM_EN/MEM_WE/MEM_ADDR/MEM_WDATA/MEM_RDATA - RAM port
//                VBLANK    - only with FB_VBLANK_ONLY_EN defined
//  Options     : FB_VBLANK_ONLY_EN - held writes issue only while VBLANK=1
//  Revision    : 1.0  initial release
// ============================================================================
module vga_fb_arbiter
   import vga_pkg::*;
(
   input  logic               CLK_IN,
   input  logic               RST,
   input  logic               PXL_EN,
   input  logic               DISP_ACTIVE,
   input  logic [COORD_W-1:0] X_COORD,
   input  logic [COORD_W-1:0] Y_COORD,
   output logic [PIXEL_W-1:0] RGB_OUT,
   input  logic               WR_VALID,
   output logic               WR_READY,
   input  logic [ADDR_W-1:0]  WR_ADDR,
   input  logic [PIXEL_W-1:0] WR_DATA,
   output logic               WR_ERR,
   output logic [STALL_W-1:0] STALL_CNT,
   output logic               MEM_EN,
   output logic               MEM_WE,
   output logic [ADDR_W-1:0]  MEM_ADDR,
   output logic [PIXEL_W-1:0] MEM_WDATA,
   input  logic [PIXEL_W-1:0] MEM_RDATA
`ifdef FB_VBLANK_ONLY_EN
   ,
   input  logic               VBLANK
`endif
);

   localparam logic [ADDR_W-1:0] FB_DEPTH_A = ADDR_W'(FB_DEPTH);

   // Address generator
   logic [ADDR_W-1:0] w_pix_addr;
   logic              w_pix_visible;

   fb_addr_calc u_addr_calc (
      .active_i  (DISP_ACTIVE),
      .x_i       (X_COORD),
      .y_i       (Y_COORD),
      .addr_o    (w_pix_addr),
      .visible_o (w_pix_visible)
   );

   // Display pipeline: stage 1 = RAM access cycle, stage 2 = data return.
   logic              s1_vld_q,  s1_vld_d;
   logic              s1_vis_q,  s1_vis_d;
   logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
   logic              s2_vld_q,  s2_vld_d;
   logic              s2_vis_q,  s2_vis_d;
   logic [PIXEL_W-1:0] rgb_q,    rgb_d;

   // Write holding register
   logic               hold_vld_q,  hold_vld_d;
   logic [ADDR_W-1:0]  hold_addr_q, hold_addr_d;
   logic [PIXEL_W-1:0] hold_data_q, hold_data_d;
   logic               err_q,       err_d;
   logic [STALL_W-1:0] stall_q,     stall_d;

   // Port owner and registered RAM interface
   owner_e             owner_q,     owner_d;
   logic               mem_en_q,    mem_en_d;
   logic               mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0]  mem_addr_q,  mem_addr_d;
   logic [PIXEL_W-1:0] mem_wdata_q, mem_wdata_d;

   logic w_accept;
   logic w_wr_in_range;
   logic w_wr_allowed;
   logic w_stall;

   assign w_accept      = WR_VALID && !hold_vld_q;
   assign w_wr_in_range = (WR_ADDR < FB_DEPTH_A);

`ifdef FB_VBLANK_ONLY_EN
   // The owner is registered, so VBLANK in this cycle gates the issue in
   // the next one; a held write waiting outside vblank counts as stalled.
   assign w_wr_allowed = VBLANK;
   assign w_stall      = hold_vld_q && (owner_q != OWN_WR) &&
                         ((owner_q == OWN_RD) || !VBLANK);
`else
   assign w_wr_allowed = 1'b1;
   assign w_stall      = hold_vld_q && (owner_q == OWN_RD);
`endif

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      // Display pipeline
      s1_vld_d  = PXL_EN;
      s1_vis_d  = PXL_EN && w_pix_visible;
      s1_addr_d = s1_addr_q;
      if (PXL_EN && w_pix_visible) begin
         s1_addr_d = w_pix_addr;
      end
      s2_vld_d = s1_vld_q;
      s2_vis_d = s1_vis_q;

      // RGB only moves when a request reaches the end of the pipe.
      rgb_d = rgb_q;
      if (s2_vld_q) begin
         rgb_d = s2_vis_q ? MEM_RDATA : BLANK_COLOR;
      end

      // Holding register: an issued write leaves at the end of its issue
      // cycle. An out-of-range write completes the handshake but is dropped.
      hold_vld_d  = hold_vld_q;
      hold_addr_d = hold_addr_q;
      hold_data_d = hold_data_q;
      if (owner_q == OWN_WR) begin
         hold_vld_d = 1'b0;
      end
      if (w_accept && w_wr_in_range) begin
         hold_vld_d  = 1'b1;
         hold_addr_d = WR_ADDR;
         hold_data_d = WR_DATA;
      end

      err_d = err_q | (w_accept && !w_wr_in_range);

      stall_d = stall_q;
      if (w_stall && (stall_q != {STALL_W{1'b1}})) begin
         stall_d = stall_q + 1'b1;
      end

      // Port owner for the next cycle: display always wins.
      if (s1_vis_d) begin
         owner_d = OWN_RD;
      end else if (hold_vld_d && w_wr_allowed) begin
         owner_d = OWN_WR;
      end else begin
         owner_d = OWN_IDLE;
      end

      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      case (owner_d)
         OWN_RD: begin
            mem_en_d   = 1'b1;
            mem_addr_d = s1_addr_d;
         end
         OWN_WR: begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = hold_addr_d;
            mem_wdata_d = hold_data_d;
         end
         default: begin
            mem_en_d = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK_IN or posedge RST) begin
      if (RST) begin
         s1_vld_q    <= 1'b0;
         s1_vis_q    <= 1'b0;
         s1_addr_q   <= '0;
         s2_vld_q    <= 1'b0;
         s2_vis_q    <= 1'b0;
         rgb_q       <= BLANK_COLOR;
         hold_vld_q  <= 1'b0;
         hold_addr_q <= '0;
         hold_data_q <= '0;
         err_q       <= 1'b0;
         stall_q     <= '0;
         owner_q     <= OWN_IDLE;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         s1_vld_q    <= s1_vld_d;
         s1_vis_q    <= s1_vis_d;
         s1_addr_q   <= s1_addr_d;
         s2_vld_q    <= s2_vld_d;
         s2_vis_q    <= s2_vis_d;
         rgb_q       <= rgb_d;
         hold_vld_q  <= hold_vld_d;
         hold_addr_q <= hold_addr_d;
         hold_data_q <= hold_data_d;
         err_q       <= err_d;
         stall_q     <= stall_d;
         owner_q     <= owner_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign RGB_OUT   = rgb_q;
   assign WR_READY  = !hold_vld_q;
   assign WR_ERR    = err_q;
   assign STALL_CNT = stall_q;
   assign MEM_EN    = mem_en_q;
   assign MEM_WE    = mem_we_q;
   assign MEM_ADDR  = mem_addr_q;
   assign MEM_WDATA = mem_wdata_q;

endmodule : vga_fb_arbiter
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_fb_arbiter
//  Description : Self-checking bench for vga_fb_arbiter. Table of scanout
//                vectors plus hand-written write/collision/saturation/reset
//                sequences. A small RAM model answers reads one cycle later.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_fb_arbiter;

   logic        CLK_IN = 1'b0;
   logic        RST;
   logic        PXL_EN;
   logic        DISP_ACTIVE;
   logic [9:0]  X_COORD;
   logic [9:0]  Y_COORD;
   logic [7:0]  RGB_OUT;
   logic        WR_VALID;
   logic        WR_READY;
   logic [18:0] WR_ADDR;
   logic [7:0]  WR_DATA;
   logic        WR_ERR;
   logic [15:0] STALL_CNT;
   logic        MEM_EN;
   logic        MEM_WE;
   logic [18:0] MEM_ADDR;
   logic [7:0]  MEM_WDATA;
   logic [7:0]  MEM_RDATA;
`ifdef FB_VBLANK_ONLY_EN
   logic        VBLANK = 1'b1;
`endif

   vga_fb_arbiter dut (
      .CLK_IN      (CLK_IN),
      .RST         (RST),
      .PXL_EN      (PXL_EN),
      .DISP_ACTIVE (DISP_ACTIVE),
      .X_COORD     (X_COORD),
      .Y_COORD     (Y_COORD),
      .RGB_OUT     (RGB_OUT),
      .WR_VALID    (WR_VALID),
      .WR_READY    (WR_READY),
      .WR_ADDR     (WR_ADDR),
      .WR_DATA     (WR_DATA),
      .WR_ERR      (WR_ERR),
      .STALL_CNT   (STALL_CNT),
      .MEM_EN      (MEM_EN),
      .MEM_WE      (MEM_WE),
      .MEM_ADDR    (MEM_ADDR),
      .MEM_WDATA   (MEM_WDATA),
      .MEM_RDATA   (MEM_RDATA)
`ifdef FB_VBLANK_ONLY_EN
      ,
      .VBLANK      (VBLANK)
`endif
   );

   always #10 CLK_IN = ~CLK_IN;

   // RAM model: synchronous read, one-cycle latency; counts write strobes.
   logic [7:0] ram [0:307199];
   int         wr_cnt = 0;

   always @(posedge CLK_IN) begin
      if (MEM_EN && !MEM_WE) MEM_RDATA <= ram[MEM_ADDR];
      if (MEM_EN && MEM_WE) begin
         ram[MEM_ADDR] <= MEM_WDATA;
         wr_cnt        <= wr_cnt + 1;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK_IN);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " rgb"},    32'(RGB_OUT),   32'h05);
      chk({tag, " ready"},  32'(WR_READY),  32'h1);
      chk({tag, " err"},    32'(WR_ERR),    32'h0);
      chk({tag, " stall"},  32'(STALL_CNT), 32'h0);
      chk({tag, " mem_en"}, 32'(MEM_EN),    32'h0);
      chk({tag, " mem_we"}, 32'(MEM_WE),    32'h0);
      chk({tag, " addr"},   32'(MEM_ADDR),  32'h0);
      chk({tag, " wdata"},  32'(MEM_WDATA), 32'h0);
   endtask

   typedef struct {
      logic        act;
      logic [9:0]  x;
      logic [9:0]  y;
      logic        exp_en;
      logic [18:0] exp_addr;
      logic [7:0]  exp_rgb;
   } vec_t;

   localparam int NV = 8;
   vec_t vecs [NV];

   initial begin
      logic [7:0] prev_rgb;
      int         c0;

      RST = 1'b1; PXL_EN = 1'b0; DISP_ACTIVE = 1'b0; X_COORD = '0; Y_COORD = '0;
      WR_VALID = 1'b0; WR_ADDR = '0; WR_DATA = '0;

      ram[1283]   = 8'hE0;
      ram[307199] = 8'h7B;
      ram[0]      = 8'h11;
      ram[640]    = 8'h42;
      ram[192100] = 8'h9C;
      ram[3205]   = 8'hC7;
      ram[100]    = 8'h00;

      //            act    x     y   en   addr     rgb
      vecs[0] = '{1'b1,   3,    2, 1'b1,   1283, 8'hE0};
      vecs[1] = '{1'b0,   3,    2, 1'b0,      0, 8'h05};
      vecs[2] = '{1'b1, 640,    2, 1'b0,      0, 8'h05};
      vecs[3] = '{1'b1, 639,  479, 1'b1, 307199, 8'h7B};
      vecs[4] = '{1'b1,   0,    0, 1'b1,      0, 8'h11};
      vecs[5] = '{1'b1,   0,  480, 1'b0,      0, 8'h05};
      vecs[6] = '{1'b1,   0,    1, 1'b1,    640, 8'h42};
      vecs[7] = '{1'b1, 100,  300, 1'b1, 192100, 8'h9C};

      // ---- reset ----
      repeat (2) tick();
      chk_reset_vals("in_reset");
      RST = 1'b0;
      repeat (3) tick();
      chk_reset_vals("after_reset");

      // ---- scanout vectors ----
      prev_rgb = 8'h05;
      for (int i = 0; i < NV; i++) begin
         PXL_EN = 1'b1; DISP_ACTIVE = vecs[i].act;
         X_COORD = vecs[i].x; Y_COORD = vecs[i].y;
         tick();                                     // n+1
         PXL_EN = 1'b0; DISP_ACTIVE = 1'b0;
         chk($sformatf("vec%0d mem_en", i), 32'(MEM_EN), 32'(vecs[i].exp_en));
         if (vecs[i].exp_en) begin
            chk($sformatf("vec%0d mem_we", i),   32'(MEM_WE),   32'h0);
            chk($sformatf("vec%0d mem_addr", i), 32'(MEM_ADDR), 32'(vecs[i].exp_addr));
         end
         tick();                                     // n+2
         chk($sformatf("vec%0d en_n2", i),  32'(MEM_EN),  32'h0);
         chk($sformatf("vec%0d rgb_n2", i), 32'(RGB_OUT), 32'(prev_rgb));
         tick();                                     // n+3
         chk($sformatf("vec%0d rgb_n3", i), 32'(RGB_OUT), 32'(vecs[i].exp_rgb));
         prev_rgb = vecs[i].exp_rgb;
      end

      // ---- write colliding with a display read ----
      PXL_EN = 1'b1; DISP_ACTIVE = 1'b1; X_COORD = 3; Y_COORD = 2;
      WR_VALID = 1'b1; WR_ADDR = 100; WR_DATA = 8'h1C;
      chk("col ready_n0", 32'(WR_READY), 32'h1);
      tick();                                        // n+1
      PXL_EN = 1'b0; DISP_ACTIVE = 1'b0; WR_VALID = 1'b0;
      chk("col rd_en",    32'(MEM_EN),   32'h1);
      chk("col rd_we",    32'(MEM_WE),   32'h0);
      chk("col rd_addr",  32'(MEM_ADDR), 32'd1283);
      chk("col ready_n1", 32'(WR_READY), 32'h0);
      tick();                                        // n+2
      chk("col wr_en",    32'(MEM_EN),    32'h1);
      chk("col wr_we",    32'(MEM_WE),    32'h1);
      chk("col wr_addr",  32'(MEM_ADDR),  32'd100);
      chk("col wr_data",  32'(MEM_WDATA), 32'h1C);
      chk("col stall",    32'(STALL_CNT), 32'd1);
      chk("col ready_n2", 32'(WR_READY),  32'h0);
      tick();                                        // n+3
      chk("col ready_n3", 32'(WR_READY),  32'h1);
      chk("col idle_n3",  32'(MEM_EN),    32'h0);
      chk("col rgb",      32'(RGB_OUT),   32'hE0);
      chk("col ram100",   32'(ram[100]),  32'h1C);

      // ---- back-to-back strobes with a write pending ----
      PXL_EN = 1'b1; DISP_ACTIVE = 1'b1; X_COORD = 0; Y_COORD = 0;
      WR_VALID = 1'b1; WR_ADDR = 50; WR_DATA = 8'hAA;
      tick();                                        // n+1
      WR_VALID = 1'b0; Y_COORD = 1;
      chk("b2b rd0_addr", 32'(MEM_ADDR), 32'd0);
      chk("b2b rd0_we",   32'(MEM_WE),   32'h0);
      chk("b2b rd0_en",   32'(MEM_EN),   32'h1);
      tick();                                        // n+2
      PXL_EN = 1'b0; DISP_ACTIVE = 1'b0;
      chk("b2b rd1_addr", 32'(MEM_ADDR),  32'd640);
      chk("b2b rd1_we",   32'(MEM_WE),    32'h0);
      chk("b2b stall2",   32'(STALL_CNT), 32'd2);
      tick();                                        // n+3
      chk("b2b wr_we",    32'(MEM_WE),    32'h1);
      chk("b2b wr_addr",  32'(MEM_ADDR),  32'd50);
      chk("b2b wr_data",  32'(MEM_WDATA), 32'hAA);
      chk("b2b stall3",   32'(STALL_CNT), 32'd3);
      chk("b2b rgb0",     32'(RGB_OUT),   32'h11);
      tick();                                        // n+4
      chk("b2b rgb1",     32'(RGB_OUT),   32'h42);
      chk("b2b ready",    32'(WR_READY),  32'h1);

      // ---- write throughput, no display traffic ----
      WR_VALID = 1'b1; WR_ADDR = 200; WR_DATA = 8'h33;
      tick();
      WR_ADDR = 201; WR_DATA = 8'h34;
      chk("tp wr0_we",   32'(MEM_WE),    32'h1);
      chk("tp wr0_addr", 32'(MEM_ADDR),  32'd200);
      chk("tp wr0_data", 32'(MEM_WDATA), 32'h33);
      chk("tp ready0",   32'(WR_READY),  32'h0);
      tick();
      chk("tp gap_en",   32'(MEM_EN),    32'h0);
      chk("tp ready1",   32'(WR_READY),  32'h1);
      tick();
      WR_VALID = 1'b0;
      chk("tp wr1_addr", 32'(MEM_ADDR),  32'd201);
      chk("tp wr1_data", 32'(MEM_WDATA), 32'h34);
      chk("tp stall",    32'(STALL_CNT), 32'd3);
      tick();

      // ---- last legal address, then first illegal one ----
      WR_VALID = 1'b1; WR_ADDR = 307199; WR_DATA = 8'h5A;
      tick();
      WR_VALID = 1'b0;
      chk("edge wr_we",   32'(MEM_WE),   32'h1);
      chk("edge wr_addr", 32'(MEM_ADDR), 32'd307199);
      chk("edge err",     32'(WR_ERR),   32'h0);
      tick();
      c0 = wr_cnt;
      WR_VALID = 1'b1; WR_ADDR = 307200; WR_DATA = 8'hFF;
      chk("oor ready", 32'(WR_READY), 32'h1);
      tick();
      WR_VALID = 1'b0;
      chk("oor err",   32'(WR_ERR), 32'h1);
      chk("oor en1",   32'(MEM_EN), 32'h0);
      tick();
      chk("oor en2",   32'(MEM_EN), 32'h0);
      repeat (5) tick();
      chk("oor err_sticky", 32'(WR_ERR), 32'h1);
      chk("oor no_write",   32'(wr_cnt), 32'(c0));

      // ---- stall saturation under continuous scanout, then async reset ----
      PXL_EN = 1'b1; DISP_ACTIVE = 1'b1; X_COORD = 5; Y_COORD = 5;
      WR_VALID = 1'b1; WR_ADDR = 10; WR_DATA = 8'h77;
      tick();
      WR_VALID = 1'b0;
      c0 = wr_cnt;
      repeat (70000) tick();
      chk("sat stall",    32'(STALL_CNT), 32'hFFFF);
      chk("sat no_write", 32'(wr_cnt),    32'(c0));
      chk("sat ready",    32'(WR_READY),  32'h0);
      chk("sat rd_addr",  32'(MEM_ADDR),  32'd3205);
      chk("sat rgb",      32'(RGB_OUT),   32'hC7);
      #4;
      RST = 1'b1;
      #1;
      chk_reset_vals("async_rst");
      PXL_EN = 1'b0; DISP_ACTIVE = 1'b0;
      repeat (2) tick();
      RST = 1'b0;
      repeat (4) tick();
      chk("post_rst no_write", 32'(wr_cnt),   32'(c0));
      chk("post_rst mem_en",   32'(MEM_EN),   32'h0);
      chk("post_rst err",      32'(WR_ERR),   32'h0);
      chk("post_rst ready",    32'(WR_READY), 32'h1);
      chk("post_rst rgb",      32'(RGB_OUT),  32'h05);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_vga_fb_arbiter
`default_nettype wire

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer RAM between two users: VGA scanout reads, driven by pixel coordinates and a pixel strobe, and host/image-loader writes over a valid/ready handshake.
- Display reads have absolute priority and fixed latency. Host writes use the free RAM slots.
- Sits between the VGA timing generator (X/Y coords, active flag) and the framebuffer RAM, and feeds the registered 8-bit RGB to the pin driver.

Parameters:
- H_RES, 640, active pixels per line.
- V_RES, 480, active lines.
- PIXEL_W, 8, RGB width (3-3-2).
- ADDR_W, 19, RAM address width (ceil log2 of H_RES*V_RES).
- BLANK_COLOR, 8'h05, RGB driven outside the active area.
- STALL_W, 16, width of the write-stall counter.

Ports:
- CLK_IN input 1: system clock, 50 MHz.
- RST input 1: reset, asynchronous, active-high.
- PXL_EN input 1: one-cycle pixel strobe, nominally every 2nd CLK_IN cycle.
- DISP_ACTIVE input 1: current pixel is inside the visible window.
- X_COORD input 10: visible-area column.
- Y_COORD input 10: visible-area row.
- RGB_OUT output PIXEL_W: registered pixel colour.
- WR_VALID input 1: host write request.
- WR_READY output 1: write holding register is empty.
- WR_ADDR input ADDR_W: host write address.
- WR_DATA input PIXEL_W: host write data.
- WR_ERR output 1: sticky flag; set when an out-of-range write address is received.
- STALL_CNT output STALL_W: saturating count of cycles in which a held write was denied the port.
- MEM_EN output 1: RAM enable.
- MEM_WE output 1: RAM write enable.
- MEM_ADDR output ADDR_W: RAM address.
- MEM_WDATA output PIXEL_W: RAM write data.
- MEM_RDATA input PIXEL_W: RAM read data, valid 1 cycle after a read enable.

Behaviour:
- One clock domain, CLK_IN. RST is asynchronous and active-high.
- Reset values: RGB_OUT=BLANK_COLOR, WR_READY=1, WR_ERR=0, STALL_CNT=0, MEM_EN=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0. All pipeline valids and the write holding register are cleared.
- Reset asserted mid-read drops the in-flight pixel. Reset asserted while a write is held discards that write.
- Display pipeline, with a strobe in cycle n:
  - Cycle n: sample PXL_EN. The request is "visible" if DISP_ACTIVE=1, X_COORD<H_RES and Y_COORD<V_RES; otherwise it is "blank". For a visible request, register addr = Y*H_RES + X.
  - Cycle n+1: a visible request drives MEM_EN=1, MEM_WE=0, MEM_ADDR=addr.
  - Edge ending n+2: RGB_OUT <= MEM_RDATA for a visible request, BLANK_COLOR for a blank one.
  - Fixed latency is 3 cycles for both cases. A blank request never touches the RAM.
- Port owner state, registered every cycle, with states IDLE, RD, WR:
  - RD when stage n+1 holds a visible request.
  - Otherwise WR when the holding register is valid.
  - Otherwise IDLE, with MEM_EN=0.
  - Display always wins.
- Write handshake:
  - A write is accepted on WR_VALID && WR_READY. WR_ADDR/WR_DATA are captured and WR_READY drops in the next cycle.
  - The earliest RAM issue is the cycle after acceptance: MEM_EN=1, MEM_WE=1.
  - The holding register clears at the edge ending the issue cycle, and WR_READY=1 again in the following cycle. Sustained throughput is 1 write per 2 cycles when no display read is pending.
- WR_ADDR >= H_RES*V_RES: the write is accepted (handshake completes), never issued, and WR_ERR is set. WR_ERR clears only on reset.
- STALL_CNT increments in every cycle where the holding register is valid and the owner is RD. It saturates at all-ones and does not wrap.
- PXL_EN on consecutive cycles is legal: both reads are served back-to-back and a pending write waits.
- Address arithmetic is unsigned at full ADDR_W width. The Y*H_RES product is formed by shift-add, (Y<<9)+(Y<<7) for 640, with no truncation before the add.

Optional Feature:
- FB_VBLANK_ONLY_EN defined:
  - Adds input VBLANK (1 bit).
  - A held write is issued only in cycles where VBLANK=1 and the owner would otherwise be IDLE. This gives tear-free updates.
  - Cycles with a held write and VBLANK=0 increment STALL_CNT.
- Undefined: there is no VBLANK port, and writes use any non-RD cycle.

Decomposition:
- Package vga_pkg:
  - H_RES, V_RES, FB_DEPTH=H_RES*V_RES, ADDR_W, PIXEL_W, BLANK_COLOR.
  - Port-owner enum {OWN_IDLE, OWN_RD, OWN_WR}.
- One sub-module, fb_addr_calc: combinational Y*H_RES+X shift-add plus the in-range check. Its result is registered by the parent.

Test Plan:
- Reset release, no stimulus -> RGB_OUT=8'h05, WR_READY=1, MEM_EN=0, STALL_CNT=0.
- PXL_EN with X=3, Y=2, active -> MEM_ADDR=1283 with MEM_WE=0 one cycle later; RAM returns 8'hE0, so RGB_OUT=8'hE0 exactly 3 cycles after the strobe.
- PXL_EN with DISP_ACTIVE=0, and also with X=640 -> no MEM_EN; RGB_OUT=8'h05 after 3 cycles.
- Write ADDR=100, DATA=8'h1C colliding with a pending display read -> read issued first, write issued next cycle; STALL_CNT=1; WR_READY high again 1 cycle after the issue.
- Write ADDR=307200 -> handshake completes, no MEM_WE, WR_ERR=1 and stays 1 until RST.
- PXL_EN held high for 70000 cycles with a write held -> STALL_CNT saturates at 16'hFFFF; assert RST mid-stream -> all outputs at reset values immediately.
